sd_spi_card_model: RTL and testbench

- SPI-mode SD card responder: the card end of the link driven by our SD initialisation master.
- Decodes 48-bit host command frames on SCLK/DI/CS and returns R1/R3/R7 responses on DO.
- Models the idle-to-ready transition of an SDHC card.
- Used in simulation benches and as a loop-back target on the FPGA board; exposes a 16-bit debug word for the SevenSegment display.

---
 rtl/sd_spi_card_model.sv | 215 +++++++++++++++++++++
 tb/tb_sd_spi_card_model.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_card_model.sv
// SPI-mode SDHC card responder: decodes 48-bit host command frames and answers
// with R1/R3/R7 responses, modelling the idle-to-ready ACMD41 handshake.
module sd_spi_card_model #(
    parameter int          NCR_BYTES  = 1,
    parameter int          IDLE_POLLS = 3,
    parameter logic [31:0] OCR        = 32'hC0FF8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        DI,
    input  logic        CS,
    output logic        DO,
    output logic        inIdle,
    output logic [15:0] debug
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RECV = 4'd1,
        ST_NCR  = 4'd2,
        ST_RESP = 4'd3
    } state_t;

    localparam logic [6:0] NCR_BITS = 7'(NCR_BYTES * 8);
    localparam logic [7:0] POLL_MAX = 8'(IDLE_POLLS);

    logic [2:0]  sclk_sync;
    logic [1:0]  di_sync;
    logic [1:0]  cs_sync;
    logic        sclk_rise, sclk_fall, di_s, cs_high;

    state_t      state, state_n;
    logic [5:0]  bit_cnt, bit_cnt_n;
    logic [45:0] rx_shift, rx_shift_n;
    logic [6:0]  cnt, cnt_n;
    logic [39:0] tx_shift, tx_shift_n;
    logic [5:0]  resp_len, resp_len_n;
    logic        do_q, do_n;
    logic        idle_q, idle_n;
    logic        app_q, app_n;
    logic [7:0]  poll_q, poll_n;
    logic [15:0] debug_q, debug_n;

    logic [5:0]  cmd_idx;
    logic [11:0] arg_lo;
    logic [7:0]  r1;
    logic [31:0] resp_tail;
    logic [5:0]  resp_bits;
    logic        idle_c, app_c;
    logic [7:0]  poll_c;

    // The start bit is not stored, so rx_shift holds frame bits 46..1 when the end bit arrives.
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign di_s      = di_sync[1];
    assign cs_high   = cs_sync[1];
    assign cmd_idx   = rx_shift[44:39];
    assign arg_lo    = rx_shift[18:7];

    assign DO     = do_q;
    assign inIdle = idle_q;
    assign debug  = debug_q;

    // Response decode for the frame about to complete, plus the card state it leaves behind.
    always_comb begin
        r1        = {5'b00000, 1'b1, 1'b0, idle_q};
        resp_tail = 32'hFFFF_FFFF;
        resp_bits = 6'd8;
        idle_c    = idle_q;
        poll_c    = poll_q;
        app_c     = 1'b0;
        case (cmd_idx)
            6'd0: begin
                r1     = 8'h01;
                idle_c = 1'b1;
                poll_c = 8'd0;
            end
            6'd8: begin
                r1        = idle_q ? 8'h01 : 8'h05;
                resp_tail = {16'h0000, 4'h0, arg_lo};
                resp_bits = 6'd40;
            end
            6'd55: begin
                r1    = {7'b0, idle_q};
                app_c = 1'b1;
            end
            6'd41: begin
                if (app_q) begin
                    if (poll_q < POLL_MAX) begin
                        r1     = 8'h01;
                        poll_c = poll_q + 8'd1;
                    end else begin
                        r1     = 8'h00;
                        idle_c = 1'b0;
                    end
                end
            end
            6'd58: begin
                r1        = {7'b0, idle_q};
                resp_tail = OCR;
                resp_bits = 6'd40;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_shift_n = rx_shift;
        cnt_n      = cnt;
        tx_shift_n = tx_shift;
        resp_len_n = resp_len;
        do_n       = do_q;
        idle_n     = idle_q;
        app_n      = app_q;
        poll_n     = poll_q;
        debug_n    = debug_q;
        if (cs_high) begin
            state_n = ST_IDLE;
            do_n    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sclk_rise && !di_s) begin
                        state_n    = ST_RECV;
                        bit_cnt_n  = 6'd1;
                        rx_shift_n = '0;
                    end
                end
                ST_RECV: begin
                    if (sclk_rise) begin
                        if (bit_cnt == 6'd47) begin
                            if (rx_shift[45] && di_s) begin
                                state_n    = ST_NCR;
                                cnt_n      = NCR_BITS;
                                tx_shift_n = {r1, resp_tail};
                                resp_len_n = resp_bits;
                                idle_n     = idle_c;
                                poll_n     = poll_c;
                                app_n      = app_c;
                                debug_n    = {ST_NCR, 2'b00, cmd_idx, r1[3:0]};
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end else begin
                            rx_shift_n = {rx_shift[44:0], di_s};
                            bit_cnt_n  = bit_cnt + 6'd1;
                        end
                    end
                end
                ST_NCR: begin
                    if (sclk_fall) begin
                        do_n = 1'b1;
                        if (cnt == 7'd1) begin
                            state_n = ST_RESP;
                            cnt_n   = {1'b0, resp_len};
                        end else begin
                            cnt_n = cnt - 7'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (sclk_fall) begin
                        if (cnt != 7'd0) begin
                            do_n       = tx_shift[39];
                            tx_shift_n = {tx_shift[38:0], 1'b1};
                            cnt_n      = cnt - 7'd1;
                        end else begin
                            do_n    = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            di_sync   <= '1;
            cs_sync   <= '1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            cnt       <= '0;
            tx_shift  <= '1;
            resp_len  <= '0;
            do_q      <= 1'b1;
            idle_q    <= 1'b1;
            app_q     <= 1'b0;
            poll_q    <= '0;
            debug_q   <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SCLK};
            di_sync   <= {di_sync[0], DI};
            cs_sync   <= {cs_sync[0], CS};
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx_shift  <= rx_shift_n;
            cnt       <= cnt_n;
            tx_shift  <= tx_shift_n;
            resp_len  <= resp_len_n;
            do_q      <= do_n;
            idle_q    <= idle_n;
            app_q     <= app_n;
            poll_q    <= poll_n;
            debug_q   <= debug_n;
        end
    end

endmodule

// File: tb/tb_sd_spi_card_model.sv
// Bench for sd_spi_card_model: acts as the SPI host and compares every returned
// byte, inIdle and debug against a command-level model of the card.
module tb_sd_spi_card_model;

    localparam int          NCR_BYTES  = 1;
    localparam int          IDLE_POLLS = 3;
    localparam logic [31:0] OCR        = 32'hC0FF8000;

    logic        clk;
    logic        reset;
    logic        SCLK;
    logic        DI;
    logic        CS;
    logic        DO;
    logic        inIdle;
    logic [15:0] debug;

    int check_count = 0;
    int error_count = 0;

    logic       model_idle;
    logic       model_app;
    int         model_polls;
    logic [7:0] exp_q[$];

    sd_spi_card_model #(
        .NCR_BYTES (NCR_BYTES),
        .IDLE_POLLS(IDLE_POLLS),
        .OCR       (OCR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .SCLK  (SCLK),
        .DI    (DI),
        .CS    (CS),
        .DO    (DO),
        .inIdle(inIdle),
        .debug (debug)
    );

    // clk posedges land at 7 mod 10 ns, away from every host action time.
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One mode-0 SPI bit: DO is sampled just before the rising edge.
    task automatic xferBit(input logic b, output logic r);
        DI = b;
        #20;
        r = DO;
        SCLK = 1'b1;
        #40;
        SCLK = 1'b0;
        #20;
    endtask

    task automatic xferByte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xferBit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic sendFrame(input logic [47:0] frame);
        logic r;
        for (int i = 47; i >= 0; i--) xferBit(frame[i], r);
    endtask

    task automatic modelReset();
        model_idle  = 1'b1;
        model_app   = 1'b0;
        model_polls = 0;
    endtask

    task automatic modelCommand(input logic [5:0] cmd, input logic [31:0] arg);
        exp_q.delete();
        case (cmd)
            6'd0: begin
                exp_q.push_back(8'h01);
                model_idle  = 1'b1;
                model_polls = 0;
            end
            6'd8: begin
                exp_q.push_back(model_idle ? 8'h01 : 8'h05);
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
                exp_q.push_back({4'h0, arg[11:8]});
                exp_q.push_back(arg[7:0]);
            end
            6'd55: exp_q.push_back({7'b0, model_idle});
            6'd58: begin
                exp_q.push_back({7'b0, model_idle});
                for (int k = 3; k >= 0; k--) exp_q.push_back(8'((OCR >> (8 * k)) & 32'hFF));
            end
            default: begin
                if (cmd == 6'd41 && model_app) begin
                    if (model_polls < IDLE_POLLS) begin
                        exp_q.push_back(8'h01);
                        model_polls++;
                    end else begin
                        exp_q.push_back(8'h00);
                        model_idle = 1'b0;
                    end
                end else begin
                    exp_q.push_back(8'h04 | {7'b0, model_idle});
                end
            end
        endcase
        model_app = (cmd == 6'd55);
    endtask

    task automatic applyStimulus(input logic [5:0] cmd, input logic [31:0] arg, input logic [6:0] crc);
        logic [7:0] rx;
        logic [7:0] exp_r1;
        modelCommand(cmd, arg);
        exp_r1 = exp_q[0];
        sendFrame({2'b01, cmd, arg, crc, 1'b1});
        for (int i = 0; i < NCR_BYTES; i++) begin
            xferByte(8'hFF, rx);
            checkOutput($sformatf("cmd%0d_ncr%0d", cmd, i), 32'(rx), 32'hFF);
        end
        foreach (exp_q[i]) begin
            xferByte(8'hFF, rx);
            checkOutput($sformatf("cmd%0d_byte%0d", cmd, i), 32'(rx), 32'(exp_q[i]));
        end
        xferByte(8'hFF, rx);
        checkOutput($sformatf("cmd%0d_trailer", cmd), 32'(rx), 32'hFF);
        checkOutput($sformatf("cmd%0d_inIdle", cmd), 32'(inIdle), 32'(model_idle));
        checkOutput($sformatf("cmd%0d_debug", cmd), 32'(debug), {16'h0, 4'h2, 2'b00, cmd, exp_r1[3:0]});
    endtask

    task automatic sendBadFrame(input logic [31:0] arg);
        logic [7:0]  rx;
        logic [47:0] frame;
        frame = {2'b01, 6'd0, arg, 7'h4A, 1'b1};
        if ($urandom_range(0, 1) == 0) frame[46] = 1'b0;
        else                           frame[0]  = 1'b0;
        sendFrame(frame);
        for (int i = 0; i < NCR_BYTES + 2; i++) begin
            xferByte(8'hFF, rx);
            checkOutput($sformatf("badframe_quiet%0d", i), 32'(rx), 32'hFF);
        end
    endtask

    task automatic makeReady();
        for (int i = 0; i <= IDLE_POLLS; i++) begin
            applyStimulus(6'd55, 32'h0, 7'($urandom));
            applyStimulus(6'd41, 32'h4000_0000, 7'($urandom));
        end
    endtask

    initial begin
        logic [7:0]  rx;
        logic        r;
        logic [47:0] cmd0_frame;
        int          pick;

        reset = 1'b1;
        CS    = 1'b1;
        SCLK  = 1'b0;
        DI    = 1'b1;
        modelReset();
        #40;
        reset = 1'b0;
        #20;
        checkOutput("reset_DO", 32'(DO), 32'h1);
        checkOutput("reset_inIdle", 32'(inIdle), 32'h1);
        checkOutput("reset_debug", 32'(debug), 32'h0);
        CS = 1'b0;
        #60;

        $display("[TB] directed initialisation sequence");
        applyStimulus(6'd0, 32'h0, 7'h4A);
        checkOutput("cmd0_debug_2001", 32'(debug), 32'h2001);
        applyStimulus(6'd8, 32'h0000_01AA, 7'h43);
        makeReady();
        checkOutput("ready_inIdle_low", 32'(inIdle), 32'h0);
        applyStimulus(6'd55, 32'h0, 7'h32);
        applyStimulus(6'd58, 32'h0, 7'h7E);
        applyStimulus(6'd17, 32'h0000_0200, 7'h2A);
        applyStimulus(6'd41, 32'h4000_0000, 7'h3B);

        $display("[TB] partial frame aborted by CS");
        cmd0_frame = {2'b01, 6'd0, 32'h0, 7'h4A, 1'b1};
        for (int i = 47; i >= 28; i--) xferBit(cmd0_frame[i], r);
        CS = 1'b1;
        #60;
        checkOutput("cs_high_DO", 32'(DO), 32'h1);
        CS = 1'b0;
        #60;
        for (int i = 0; i < 5; i++) begin
            xferByte(8'hFF, rx);
            checkOutput($sformatf("partial_quiet%0d", i), 32'(rx), 32'hFF);
        end
        applyStimulus(6'd0, 32'h0, 7'h4A);
        applyStimulus(6'd41, 32'h4000_0000, 7'h3B);

        $display("[TB] reset during R7 response");
        makeReady();
        modelCommand(6'd8, 32'h0000_01AA);
        sendFrame({2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b1});
        for (int i = 0; i < NCR_BYTES + 2; i++) xferByte(8'hFF, rx);
        for (int i = 0; i < 4; i++) xferBit(1'b1, r);
        #20;
        checkOutput("pre_reset_DO", 32'(DO), 32'h0);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_resp_DO", 32'(DO), 32'h1);
        checkOutput("reset_mid_resp_inIdle", 32'(inIdle), 32'h1);
        #29;
        reset = 1'b0;
        modelReset();
        #60;
        applyStimulus(6'd58, 32'h0, 7'h7E);

        $display("[TB] randomized command stream");
        for (int n = 0; n < 30; n++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0:       applyStimulus(6'd0, $urandom, 7'($urandom));
                1:       applyStimulus(6'd8, $urandom, 7'($urandom));
                2, 3:    applyStimulus(6'd55, $urandom, 7'($urandom));
                4, 5:    applyStimulus(6'd41, $urandom, 7'($urandom));
                6:       applyStimulus(6'd58, $urandom, 7'($urandom));
                7:       applyStimulus(6'($urandom), $urandom, 7'($urandom));
                8:       sendBadFrame($urandom);
                default: applyStimulus(6'd17, $urandom, 7'($urandom));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
